// File: rtl/burst_pulse_gen.sv
// burst_pulse_gen: emits a burst of N pulses with programmable period and high time
module burst_pulse_gen #(
    parameter int PERIOD_W = 16,
    parameter int COUNT_W  = 8
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                start_in,
    input  logic                abort_in,
    input  logic [PERIOD_W-1:0] period_in,
    input  logic [PERIOD_W-1:0] high_in,
    input  logic [COUNT_W-1:0]  count_in,
    output logic                pulse_out,
    output logic                evt_out,
    output logic                busy_out,
    output logic                done_out,
    output logic [COUNT_W-1:0]  sent_out
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;

    localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);
    localparam logic [PERIOD_W-1:0] TWO = PERIOD_W'(2);

    state_t               state;
    logic [PERIOD_W-1:0]  cnt;
    logic [PERIOD_W-1:0]  pe;
    logic [PERIOD_W-1:0]  he;
    logic [COUNT_W-1:0]   n;
    logic [PERIOD_W-1:0]  pe_calc;
    logic [PERIOD_W-1:0]  he_calc;

    // Clamp the requested period to at least 2 and the high time into 1..Pe-1,
    // which guarantees a non-empty low phase and an underflow-free Pe-He.
    always_comb begin
        pe_calc = (period_in < TWO) ? TWO : period_in;
        he_calc = (high_in == '0) ? ONE : ((high_in >= pe_calc) ? pe_calc - ONE : high_in);
    end

    // Burst sequencer; cnt holds the remaining cycles of the current phase minus one.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state     <= IDLE;
            cnt       <= '0;
            pe        <= '0;
            he        <= '0;
            n         <= '0;
            pulse_out <= 1'b0;
            evt_out   <= 1'b0;
            busy_out  <= 1'b0;
            done_out  <= 1'b0;
            sent_out  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_out <= 1'b0;
                    if (start_in && !abort_in) begin
                        pe       <= pe_calc;
                        he       <= he_calc;
                        n        <= count_in;
                        if (count_in != '0) begin
                            state     <= HIGH;
                            cnt       <= he_calc - ONE;
                            pulse_out <= 1'b1;
                            evt_out   <= 1'b1;
                            busy_out  <= 1'b1;
                            sent_out  <= COUNT_W'(1);
                        end else begin
                            state    <= DONE;
                            done_out <= 1'b1;
                            sent_out <= '0;
                        end
                    end
                end
                HIGH: begin
                    evt_out <= 1'b0;
                    if (abort_in) begin
                        state     <= IDLE;
                        pulse_out <= 1'b0;
                        busy_out  <= 1'b0;
                    end else if (cnt == '0) begin
                        state     <= LOW;
                        cnt       <= pe - he - ONE;
                        pulse_out <= 1'b0;
                    end else begin
                        cnt <= cnt - ONE;
                    end
                end
                LOW: begin
                    if (abort_in) begin
                        state    <= IDLE;
                        busy_out <= 1'b0;
                    end else if (cnt != '0) begin
                        cnt <= cnt - ONE;
                    end else if (sent_out < n) begin
                        state     <= HIGH;
                        cnt       <= he - ONE;
                        pulse_out <= 1'b1;
                        evt_out   <= 1'b1;
                        sent_out  <= sent_out + COUNT_W'(1);
                    end else begin
                        state    <= DONE;
                        busy_out <= 1'b0;
                        done_out <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    done_out <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_burst_pulse_gen.sv
// tb_burst_pulse_gen: directed checks of burst timing, clamping, abort and reset
module tb_burst_pulse_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] period = '0;
    logic [15:0] high = '0;
    logic [7:0]  count = '0;
    logic        pulse, evt, busy, done;
    logic [7:0]  sent;
    int compared = 0;
    int mismatched = 0;

    burst_pulse_gen #(.PERIOD_W(16), .COUNT_W(8)) dut (
        .clk_in(clk), .rst_in(rst), .start_in(start), .abort_in(abort),
        .period_in(period), .high_in(high), .count_in(count),
        .pulse_out(pulse), .evt_out(evt), .busy_out(busy), .done_out(done), .sent_out(sent)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string name, input int c, input logic ep, input logic ee,
                       input logic eb, input logic ed, input logic [7:0] es);
        chk($sformatf("%s c%0d pulse", name, c), 32'(pulse), 32'(ep));
        chk($sformatf("%s c%0d evt", name, c), 32'(evt), 32'(ee));
        chk($sformatf("%s c%0d busy", name, c), 32'(busy), 32'(eb));
        chk($sformatf("%s c%0d done", name, c), 32'(done), 32'(ed));
        chk($sformatf("%s c%0d sent", name, c), 32'(sent), 32'(es));
    endtask

    task automatic go(input logic [15:0] p, input logic [15:0] h, input logic [7:0] n);
        period = p;
        high = h;
        count = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        cyc("reset", 0, 0, 0, 0, 0, 8'd0);

        // P=4 H=2 N=3 basic burst
        go(16'd4, 16'd2, 8'd3);
        for (int c = 1; c <= 14; c++) begin
            cyc("basic", c, c inside {1, 2, 5, 6, 9, 10}, c inside {1, 5, 9},
                c >= 1 && c <= 12, c == 13, c >= 9 ? 8'd3 : (c >= 5 ? 8'd2 : 8'd1));
            if (c < 14) tick();
        end

        // start re-asserted (with new fields) at cycle 3 must not disturb the burst
        go(16'd4, 16'd2, 8'd3);
        for (int c = 1; c <= 14; c++) begin
            cyc("restart", c, c inside {1, 2, 5, 6, 9, 10}, c inside {1, 5, 9},
                c >= 1 && c <= 12, c == 13, c >= 9 ? 8'd3 : (c >= 5 ? 8'd2 : 8'd1));
            if (c == 3) begin
                start = 1'b1;
                period = 16'd7;
                count = 8'd9;
            end
            if (c < 14) tick();
            start = 1'b0;
        end

        // P=1 H=0 N=2 clamps to Pe=2 He=1
        go(16'd1, 16'd0, 8'd2);
        for (int c = 1; c <= 6; c++) begin
            cyc("clamp", c, c inside {1, 3}, c inside {1, 3}, c >= 1 && c <= 4, c == 5,
                c >= 3 ? 8'd2 : 8'd1);
            if (c < 6) tick();
        end

        // H >= P clamps to He=P-1: P=3 H=9 N=1 -> high cycles 1-2, low 3, done 4
        go(16'd3, 16'd9, 8'd1);
        for (int c = 1; c <= 5; c++) begin
            cyc("hclamp", c, c inside {1, 2}, c == 1, c >= 1 && c <= 3, c == 4, 8'd1);
            if (c < 5) tick();
        end

        // N=0: immediate done, no pulse
        go(16'd4, 16'd2, 8'd0);
        for (int c = 1; c <= 3; c++) begin
            cyc("zero", c, 0, 0, 0, c == 1, 8'd0);
            if (c < 3) tick();
        end

        // P=10 H=3 N=5 aborted at cycle 12
        go(16'd10, 16'd3, 8'd5);
        for (int c = 1; c <= 16; c++) begin
            cyc("abort", c, c inside {[1:3], [11:12]}, c inside {1, 11}, c >= 1 && c <= 12, 0,
                c >= 11 ? 8'd2 : 8'd1);
            if (c == 12) abort = 1'b1;
            if (c < 16) tick();
            abort = 1'b0;
        end

        // reset at cycle 6 of the basic burst, new start at cycle 8
        go(16'd4, 16'd2, 8'd3);
        for (int c = 1; c <= 6; c++) begin
            cyc("rst", c, c inside {1, 2, 5, 6}, c inside {1, 5}, 1, 0,
                c >= 5 ? 8'd2 : 8'd1);
            if (c < 6) tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cyc("rst", 7, 0, 0, 0, 0, 8'd0);
        tick();
        go(16'd4, 16'd2, 8'd3);
        cyc("rst", 9, 1, 1, 1, 0, 8'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        cyc("rst_abort", 10, 0, 0, 0, 0, 8'd1);

        // start and abort together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            cyc("blocked", c, 0, 0, 0, 0, 8'd1);
            if (c < 3) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
